// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - shared DMG divider with NUM_CH independent TIMA/TMA/TAC timer channels
// Reproduces falling-edge increment glitches and the 4-tick delayed overflow reload.
module multi_timer #(
  parameter int          NUM_CH    = 1,
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter int          DIV_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [15:0]       addr,
  input  logic [7:0]        wdata,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [7:0]        rdata,
  output logic              hit,
  output logic [NUM_CH-1:0] irq
);

  typedef enum logic [1:0] {ST_RUN, ST_DELAY, ST_RELOAD} state_t;

  localparam logic [15:0] SPAN = 16'(1 + 3 * NUM_CH);

  logic [DIV_W-1:0]  div_q;
  logic [15:0]       div16;
  logic [7:0]        div_hi;
  logic [15:0]       offset;
  logic              in_range;
  logic              div_we;
  logic [NUM_CH-1:0] tima_we;
  logic [NUM_CH-1:0] tma_we;
  logic [NUM_CH-1:0] tac_we;
  logic [7:0]        tima_v [NUM_CH];
  logic [7:0]        tma_v  [NUM_CH];
  logic [2:0]        tac_v  [NUM_CH];
  logic [7:0]        rd_val;

  // Offset wraps for addresses below BASE_ADDR, so one compare covers both ends.
  assign offset   = addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign div_we   = wr_en && (offset == 16'd0);
  assign div16    = 16'(div_q);
  assign div_hi   = 8'(div16 >> 8);

  always_comb begin
    tima_we = '0;
    tma_we  = '0;
    tac_we  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      tima_we[k] = wr_en && (offset == 16'(1 + 3 * k));
      tma_we[k]  = wr_en && (offset == 16'(2 + 3 * k));
      tac_we[k]  = wr_en && (offset == 16'(3 + 3 * k));
    end
  end

  always_comb begin
    rd_val = 8'hFF;
    if (offset == 16'd0) rd_val = div_hi;
    for (int k = 0; k < NUM_CH; k++) begin
      if (offset == 16'(1 + 3 * k)) rd_val = tima_v[k];
      if (offset == 16'(2 + 3 * k)) rd_val = tma_v[k];
      if (offset == 16'(3 + 3 * k)) rd_val = {5'b11111, tac_v[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      rdata <= 8'hFF;
      hit   <= 1'b0;
    end else begin
      if (div_we)    div_q <= '0;
      else if (tick) div_q <= div_q + DIV_W'(1);
      if (rd_en) rdata <= rd_val;
      hit <= (rd_en || wr_en) && in_range;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_t     state_q, state_d;
    logic [7:0] tima_q, tima_d, tma_q;
    logic [2:0] tac_q, cnt_q, cnt_d;
    logic       sel_bit, src, src_prev, fall;

    always_comb begin
      sel_bit = div_q[9];
      case (tac_q[1:0])
        2'b01:   sel_bit = div_q[3];
        2'b10:   sel_bit = div_q[5];
        2'b11:   sel_bit = div_q[7];
        default: sel_bit = div_q[9];
      endcase
    end

    // src_prev follows every clk, so DIV/TAC writes produce glitch edges too.
    assign src  = tac_q[2] & sel_bit;
    assign fall = src_prev & ~src;

    always_comb begin
      state_d = state_q;
      tima_d  = tima_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_RUN: begin
          if (tima_we[k]) begin
            tima_d = wdata;
          end else if (fall) begin
            if (tima_q == 8'hFF) begin
              tima_d  = 8'h00;
              cnt_d   = 3'd4;
              state_d = ST_DELAY;
            end else begin
              tima_d = tima_q + 8'd1;
            end
          end
        end
        ST_DELAY: begin
          if (tima_we[k]) begin
            tima_d  = wdata;
            state_d = ST_RUN;
          end else if (tick) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = ST_RELOAD;
          end
        end
        ST_RELOAD: begin
          // A TMA write landing now is what gets loaded; TIMA writes are dropped.
          tima_d  = tma_we[k] ? wdata : tma_q;
          state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_RUN;
        tima_q   <= 8'h00;
        tma_q    <= 8'h00;
        tac_q    <= 3'd0;
        cnt_q    <= 3'd0;
        src_prev <= 1'b0;
      end else begin
        state_q  <= state_d;
        tima_q   <= tima_d;
        cnt_q    <= cnt_d;
        src_prev <= src;
        if (tma_we[k]) tma_q <= wdata;
        if (tac_we[k]) tac_q <= wdata[2:0];
      end
    end

    assign tima_v[k] = tima_q;
    assign tma_v[k]  = tma_q;
    assign tac_v[k]  = tac_q;
    assign irq[k]    = (state_q == ST_RELOAD);
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed self-checking bench for multi_timer with two channels
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rdata;
  logic        hit;
  logic [1:0]  irq;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  d;
  logic        h;

  multi_timer #(.NUM_CH(2), .BASE_ADDR(16'hFF04), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .tick(tick), .addr(addr), .wdata(wdata),
    .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] v);
    addr = a; wdata = v; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    addr = a; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    d = rdata; h = hit;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rdata !== 8'hFF) begin failures++; $display("FAIL reset_rdata got=%h exp=ff", rdata); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
    checks++; if (irq !== 2'b00) begin failures++; $display("FAIL reset_irq got=%b exp=00", irq); end
    bus_rd(16'hFF04);
    checks++; if (d !== 8'h00 || h !== 1'b1) begin failures++; $display("FAIL reset_div got=%h/%b exp=00/1", d, h); end
    bus_rd(16'hFF07);
    checks++; if (d !== 8'hF8) begin failures++; $display("FAIL reset_tac got=%h exp=f8", d); end
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_tima got=%h exp=00", d); end
  endtask

  task automatic test_divider();
    do_reset();
    ticks(256);
    bus_rd(16'hFF04);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL div_256 got=%h exp=01", d); end
    tick = 1'b1;
    bus_wr(16'hFF04, 8'h5A);
    tick = 1'b0;
    checks++; if (dut.div_q !== 16'h0000) begin failures++; $display("FAIL div_clear got=%h exp=0000", dut.div_q); end
    bus_rd(16'hFF04);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL div_read_clear got=%h exp=00", d); end
  endtask

  task automatic test_count();
    do_reset();
    bus_wr(16'hFF07, 8'h05);
    ticks(48);
    step();
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL count_tac05 got=%h exp=03", d); end
    do_reset();
    bus_wr(16'hFF07, 8'h04);
    ticks(1023);
    step();
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL count_tac04_early got=%h exp=00", d); end
    ticks(1);
    step();
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL count_tac04 got=%h exp=01", d); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus_wr(16'hFF06, 8'h42);
    bus_wr(16'hFF05, 8'hFE);
    bus_wr(16'hFF07, 8'h05);
    ticks(32);
    bus_rd(16'hFF05);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL ovf_pre got=%h exp=ff", d); end
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL ovf_zero got=%h exp=00", d); end
    for (int i = 1; i <= 4; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      checks++; if (irq[0] !== (i == 4)) begin failures++; $display("FAIL ovf_irq_tick%0d got=%b exp=%b", i, irq[0], (i == 4)); end
      if (i == 3) begin
        bus_rd(16'hFF05);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL ovf_delay_tima got=%h exp=00", d); end
      end
    end
    step();
    checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL ovf_irq_width got=%b exp=0", irq[0]); end
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h42) begin failures++; $display("FAIL ovf_reload got=%h exp=42", d); end
  endtask

  task automatic test_cancel();
    int ic;
    do_reset();
    bus_wr(16'hFF06, 8'h42);
    bus_wr(16'hFF05, 8'hFE);
    bus_wr(16'hFF07, 8'h05);
    ticks(32);
    step();
    ticks(2);
    bus_wr(16'hFF05, 8'h10);
    ic = 0;
    tick = 1'b1;
    repeat (8) begin
      step();
      if (irq[0]) ic++;
    end
    tick = 1'b0;
    checks++; if (ic !== 0) begin failures++; $display("FAIL cancel_irq got=%0d exp=0", ic); end
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h10) begin failures++; $display("FAIL cancel_tima got=%h exp=10", d); end
  endtask

  task automatic test_reload_boundary();
    do_reset();
    bus_wr(16'hFF06, 8'h42);
    bus_wr(16'hFF05, 8'hFE);
    bus_wr(16'hFF07, 8'h05);
    ticks(32);
    step();
    ticks(4);
    checks++; if (irq[0] !== 1'b1) begin failures++; $display("FAIL rb_irq1 got=%b exp=1", irq[0]); end
    bus_wr(16'hFF05, 8'h99);
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h42) begin failures++; $display("FAIL rb_tima_write_ignored got=%h exp=42", d); end
    bus_wr(16'hFF05, 8'hFF);
    ticks(12);
    step();
    ticks(4);
    checks++; if (irq[0] !== 1'b1) begin failures++; $display("FAIL rb_irq2 got=%b exp=1", irq[0]); end
    bus_wr(16'hFF06, 8'h77);
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL rb_tma_write_wins got=%h exp=77", d); end
    bus_rd(16'hFF06);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL rb_tma got=%h exp=77", d); end
  endtask

  task automatic test_glitch();
    do_reset();
    bus_wr(16'hFF07, 8'h05);
    ticks(8);
    bus_wr(16'hFF04, 8'h00);
    step();
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL glitch_div got=%h exp=01", d); end
    ticks(8);
    bus_wr(16'hFF07, 8'h01);
    step();
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL glitch_tac got=%h exp=02", d); end
    bus_wr(16'hFF07, 8'h05);
    step();
    bus_wr(16'hFF04, 8'h00);
    bus_wr(16'hFF05, 8'h33);
    step();
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h33) begin failures++; $display("FAIL glitch_write_wins got=%h exp=33", d); end
  endtask

  task automatic test_two_channels();
    int f0, f1, c0, c1;
    do_reset();
    bus_wr(16'hFF05, 8'hFF);
    bus_wr(16'hFF06, 8'h10);
    bus_wr(16'hFF07, 8'h05);
    bus_wr(16'hFF08, 8'hFF);
    bus_wr(16'hFF09, 8'h5C);
    bus_wr(16'hFF0A, 8'h06);
    f0 = 0; f1 = 0; c0 = 0; c1 = 0;
    tick = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (irq[0]) begin c0++; if (f0 == 0) f0 = i; end
      if (irq[1]) begin c1++; if (f1 == 0) f1 = i; end
    end
    tick = 1'b0;
    checks++; if (f0 !== 21) begin failures++; $display("FAIL two_irq0_cycle got=%0d exp=21", f0); end
    checks++; if (f1 !== 69) begin failures++; $display("FAIL two_irq1_cycle got=%0d exp=69", f1); end
    checks++; if (c0 !== 1 || c1 !== 1) begin failures++; $display("FAIL two_irq_counts got=%0d/%0d exp=1/1", c0, c1); end
    bus_rd(16'hFF08);
    checks++; if (d !== 8'h5C) begin failures++; $display("FAIL two_ch1_tima got=%h exp=5c", d); end
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h15) begin failures++; $display("FAIL two_ch0_tima got=%h exp=15", d); end
    bus_rd(16'hFF0A);
    checks++; if (d !== 8'hFE || h !== 1'b1) begin failures++; $display("FAIL two_ch1_tac got=%h/%b exp=fe/1", d, h); end
    bus_rd(16'hFF0D);
    checks++; if (d !== 8'hFF || h !== 1'b0) begin failures++; $display("FAIL two_unmapped got=%h/%b exp=ff/0", d, h); end
  endtask

  task automatic test_bus();
    do_reset();
    bus_wr(16'hFF06, 8'h11);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL bus_write_hit got=%b exp=1", hit); end
    addr = 16'hFF06; wdata = 8'h22; rd_en = 1'b1; wr_en = 1'b1;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    checks++; if (rdata !== 8'h11) begin failures++; $display("FAIL bus_rdwr_old got=%h exp=11", rdata); end
    bus_rd(16'hFF06);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL bus_rdwr_new got=%h exp=22", d); end
    bus_wr(16'hFF03, 8'h55);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL bus_below_hit got=%b exp=0", hit); end
    bus_rd(16'hFF03);
    checks++; if (d !== 8'hFF || h !== 1'b0) begin failures++; $display("FAIL bus_below_read got=%h/%b exp=ff/0", d, h); end
  endtask

  task automatic test_reset_mid_delay();
    int ic;
    do_reset();
    bus_wr(16'hFF06, 8'h42);
    bus_wr(16'hFF05, 8'hFF);
    bus_wr(16'hFF07, 8'h05);
    ticks(16);
    step();
    ticks(2);
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rmd_in_delay got=%h exp=00", d); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (rdata !== 8'hFF || hit !== 1'b0) begin failures++; $display("FAIL rmd_bus got=%h/%b exp=ff/0", rdata, hit); end
    ic = 0;
    tick = 1'b1;
    repeat (8) begin
      step();
      if (irq != 2'b00) ic++;
    end
    tick = 1'b0;
    checks++; if (ic !== 0) begin failures++; $display("FAIL rmd_irq got=%0d exp=0", ic); end
    bus_rd(16'hFF07);
    checks++; if (d !== 8'hF8) begin failures++; $display("FAIL rmd_tac got=%h exp=f8", d); end
    bus_rd(16'hFF05);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rmd_tima got=%h exp=00", d); end
    bus_rd(16'hFF06);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rmd_tma got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_count();
    test_overflow();
    test_cancel();
    test_reload_boundary();
    test_glitch();
    test_two_channels();
    test_bus();
    test_reset_mid_delay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
